// File: rtl/ex_store_buffer_if.sv
// Drain-side bus of the store buffer: request/accept/complete handshake.
// master = store buffer, slave = data SRAM port.
interface ex_store_buffer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [BE_W-1:0]   mem_wen_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_addr_ok_i;
    logic              mem_data_ok_i;

    modport master (
        output mem_req_o, mem_addr_o, mem_wen_o, mem_wdata_o,
        input  mem_addr_ok_i, mem_data_ok_i
    );

    modport slave (
        input  mem_req_o, mem_addr_o, mem_wen_o, mem_wdata_o,
        output mem_addr_ok_i, mem_data_ok_i
    );
endinterface

// File: rtl/ex_store_buffer.sv
// ex_store_buffer: committed-store FIFO with merge, draining to the data SRAM.
// Define STB_LOAD_FWD_EN to forward fully-covered loads from the buffer.
module ex_store_buffer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4,
    localparam int BE_W  = DATA_W / 8,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stb_push_i,
    input  logic [ADDR_W-1:0] stb_addr_i,
    input  logic [BE_W-1:0]   stb_wen_i,
    input  logic [DATA_W-1:0] stb_wdata_i,
    input  logic              ld_req_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    output logic              stb_stallreq_o,
    output logic              stb_full_o,
    output logic              stb_empty_o,
    output logic [CW-1:0]     stb_count_o,
    output logic              ld_hit_o,
    output logic [DATA_W-1:0] ld_fwd_data_o,
    ex_store_buffer_if.master mem
);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(BE_W);
    localparam int WW = ADDR_W - OW;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t            state, state_n;
    logic [WW-1:0]     e_word [DEPTH];
    logic [BE_W-1:0]   e_wen  [DEPTH];
    logic [DATA_W-1:0] e_data [DEPTH];
    logic [PW-1:0]     head, tail, youngest, idx;
    logic [CW-1:0]     count;
    logic [WW-1:0]     st_word, ld_word;
    logic              full, busy, pop, merge, alloc, reject, conflict;
    logic              unused_low;

    assign st_word    = stb_addr_i[ADDR_W-1:OW];
    assign ld_word    = ld_addr_i[ADDR_W-1:OW];
    assign unused_low = ^{stb_addr_i[OW-1:0], ld_addr_i[OW-1:0]};

    assign youngest = tail - 1'b1;
    assign full     = (count == CW'(DEPTH));
    assign busy     = (state != IDLE);
    // The in-flight head is frozen; a push to its word allocates a new entry.
    assign merge  = stb_push_i & ~full & (count != '0)
                  & (e_word[youngest] == st_word)
                  & ~(busy & (youngest == head));
    assign alloc  = stb_push_i & ~full & ~merge;
    assign reject = stb_push_i & full;
    assign pop    = ((state == REQ) & mem.mem_addr_ok_i & mem.mem_data_ok_i)
                  | ((state == WAIT) & mem.mem_data_ok_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                e_word[i] <= '0;
                e_wen[i]  <= '0;
                e_data[i] <= '0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (alloc) begin
                e_word[tail] <= st_word;
                e_wen[tail]  <= stb_wen_i;
                e_data[tail] <= stb_wdata_i;
                tail         <= tail + 1'b1;
            end
            if (merge) begin
                e_wen[youngest] <= e_wen[youngest] | stb_wen_i;
                for (int b = 0; b < BE_W; b++)
                    if (stb_wen_i[b])
                        e_data[youngest][8*b +: 8] <= stb_wdata_i[8*b +: 8];
            end
            if (pop)
                head <= head + 1'b1;
            count <= count + CW'(alloc) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // A store arriving into an empty buffer is requested on the next cycle.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if ((count != '0) || alloc) state_n = REQ;
            REQ:     if (mem.mem_addr_ok_i)
                         state_n = mem.mem_data_ok_i ? IDLE : WAIT;
            WAIT:    if (mem.mem_data_ok_i) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        mem.mem_req_o   = (state == REQ);
        mem.mem_addr_o  = ADDR_W'(e_word[head]) << OW;
        mem.mem_wen_o   = e_wen[head];
        mem.mem_wdata_o = e_data[head];
    end

`ifdef STB_LOAD_FWD_EN
    logic [PW-1:0] hit_idx;
`endif

    // Walk oldest to youngest so the last match is the youngest one.
    always_comb begin
        conflict = 1'b0;
        idx      = '0;
`ifdef STB_LOAD_FWD_EN
        hit_idx  = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((CW'(i) < count) && (e_word[idx] == ld_word)) begin
                conflict = 1'b1;
`ifdef STB_LOAD_FWD_EN
                hit_idx  = idx;
`endif
            end
        end
    end

`ifdef STB_LOAD_FWD_EN
    assign ld_hit_o      = ld_req_i & conflict & (&e_wen[hit_idx]);
    assign ld_fwd_data_o = ld_hit_o ? e_data[hit_idx] : '0;
`else
    assign ld_hit_o      = 1'b0;
    assign ld_fwd_data_o = '0;
`endif

    assign stb_stallreq_o = reject | (ld_req_i & conflict & ~ld_hit_o);
    assign stb_full_o     = full;
    assign stb_empty_o    = (count == '0) && (state == IDLE);
    assign stb_count_o    = count;
endmodule
